cv32e40p_lce_detector: RTL and testbench
========================================

Name: cv32e40p_lce_detector

Overview:
Downstream checker for the security-marker instruction stream. It sits at the ID-stage input, after the IF-stage marker inserter. It counts valid non-marker instructions between consecutive security markers (JAL x0,0 = 32'h0000_006F). If a basic block runs longer than MAX_BB_LEN, which signals a loss of control-flow execution, it raises a sticky alarm. Pipeline flushes (taken branch, exception) restart the count, because markers in flushed slots never reach this stage.

Parameters:
MAX_BB_LEN, 8, max consecutive non-marker instructions allowed between markers; must equal the inserter's value; legal range 3..1023.
MARKER_CNT_WIDTH, 16, width of the saturating marker-seen counter.

Ports:
clk  in  1  core clock.
rst_n  in  1  reset; asynchronous, active-low.
enable_i  in  1  detector enable (CSR-controlled).
instr_valid_i  in  1  instr_i accepted by ID this cycle.
instr_i  in  32  instruction word (post-insertion).
flush_i  in  1  pipeline flush (taken branch/jump, exception, debug entry).
clear_i  in  1  acknowledge/clear of a pending alarm.
alarm_o  out  1  sticky loss-of-control-flow alarm.
bb_cnt_o  out  $clog2(MAX_BB_LEN+2)  current non-marker count.
marker_cnt_o  out  MARKER_CNT_WIDTH  markers seen since enable; saturating.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is asynchronous and active-low on rst_n.
  - Reset state: state=IDLE, bb_cnt=0, marker_cnt=0, alarm_o=0.
- Definitions:
  - accept = instr_valid_i && instr_i != 32'h0. All-zero words are bubbles and are ignored.
  - is_marker = (instr_i == 32'h0000_006F).
- FSM states: IDLE, COUNT, ALARM. All outputs are registered.
- IDLE:
  - Counters hold.
  - enable_i=1 → COUNT, with bb_cnt<=0 and marker_cnt<=0.
- COUNT, priority highest first:
  1. enable_i=0 → IDLE; counters hold their last values.
  2. flush_i=1 → bb_cnt<=0. Any simultaneous accept is discarded.
  3. accept && is_marker → bb_cnt<=0; marker_cnt<=marker_cnt+1, saturating at all-ones.
  4. accept && !is_marker:
     - If bb_cnt == MAX_BB_LEN → ALARM, bb_cnt<=MAX_BB_LEN+1, alarm_o<=1.
     - Otherwise bb_cnt<=bb_cnt+1.
  5. No accept → hold.
- Latency: alarm_o rises in the cycle after the clock edge that samples the (MAX_BB_LEN+1)-th consecutive non-marker accept.
- ALARM:
  - alarm_o stays 1 and bb_cnt freezes at MAX_BB_LEN+1.
  - Further instructions, markers and flushes are ignored.
  - clear_i=1 with enable_i=1 → COUNT, bb_cnt<=0, alarm_o<=0 (marker_cnt kept).
  - enable_i=0 → IDLE, alarm_o<=0. This takes priority over clear_i.
- Count boundaries:
  - Exactly MAX_BB_LEN non-marker instructions followed by a marker is legal.
  - bb_cnt never exceeds MAX_BB_LEN+1.
- Simultaneous events:
  - flush_i with a marker accept: the flush wins; marker_cnt is not incremented.
  - clear_i in COUNT or IDLE has no effect.
- Reset mid-operation (rst_n low in any state, including ALARM): immediate return to the reset state. alarm_o clears asynchronously.

Test Plan:
- Legal stream: MAX_BB_LEN=8, enable=1, repeating pattern of 8 ADDI + 1 marker, 5 times → alarm_o stays 0, bb_cnt_o peaks at 8, marker_cnt_o=5.
- Missing marker: 9 consecutive ADDI (32'h00100093) → bb_cnt_o=8 after the 8th; alarm_o=1 one cycle after the 9th is sampled; bb_cnt_o=9; later markers leave it unchanged.
- Flush restart: 6 ADDI, flush_i pulse, then 8 ADDI + marker → no alarm; bb_cnt_o=0 after the flush; flush asserted together with a marker leaves marker_cnt_o unchanged.
- Bubbles: 8 ADDI interleaved with 20 valid 32'h0 words, then a marker → no alarm, bb_cnt_o reaches only 8.
- Clear/disable: in ALARM, assert clear_i → COUNT, alarm_o=0, bb_cnt_o=0; separately, enable_i=0 in ALARM → IDLE, alarm_o=0; then 9 ADDI while disabled → no alarm.
- Async reset: assert rst_n=0 mid-cycle while in ALARM → alarm_o=0 immediately, all counters 0, state IDLE; marker_cnt saturation is checked with MARKER_CNT_WIDTH=2 and 5 markers → 3.

Source files
------------

// File: rtl/cv32e40p_lce_detector.sv
// Loss-of-control-flow detector at the ID-stage input. It counts accepted non-marker
// instructions between security markers and raises a sticky alarm when a basic block runs too long.
module cv32e40p_lce_detector #(
   parameter int unsigned MAX_BB_LEN       = 8,
   parameter int unsigned MARKER_CNT_WIDTH = 16
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              enable_i,
   input  logic                              instr_valid_i,
   input  logic [31:0]                       instr_i,
   input  logic                              flush_i,
   input  logic                              clear_i,
   output logic                              alarm_o,
   output logic [$clog2(MAX_BB_LEN+2)-1:0]   bb_cnt_o,
   output logic [MARKER_CNT_WIDTH-1:0]       marker_cnt_o
);

   localparam int unsigned CNT_W  = $clog2(MAX_BB_LEN + 2);
   localparam logic [31:0] MARKER = 32'h0000_006F;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_COUNT = 2'd1;
   localparam logic [1:0] S_ALARM = 2'd2;

   logic [1:0]                  r_state;
   logic [1:0]                  w_state_nxt;
   logic [CNT_W-1:0]            r_bb_cnt;
   logic [CNT_W-1:0]            w_bb_cnt_nxt;
   logic [MARKER_CNT_WIDTH-1:0] r_marker_cnt;
   logic [MARKER_CNT_WIDTH-1:0] w_marker_cnt_nxt;
   logic                        r_alarm;
   logic                        w_alarm_nxt;
   logic                        w_accept;
   logic                        w_is_marker;

   // All-zero words are pipeline bubbles and never count.
   assign w_accept    = instr_valid_i && (instr_i != 32'h0);
   assign w_is_marker = (instr_i == MARKER);

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_bb_cnt     <= '0;
         r_marker_cnt <= '0;
         r_alarm      <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_bb_cnt     <= w_bb_cnt_nxt;
         r_marker_cnt <= w_marker_cnt_nxt;
         r_alarm      <= w_alarm_nxt;
      end
   end

   // Next-state and next-output logic; flush outranks any instruction in the same cycle.
   always_comb begin
      w_state_nxt      = r_state;
      w_bb_cnt_nxt     = r_bb_cnt;
      w_marker_cnt_nxt = r_marker_cnt;
      w_alarm_nxt      = r_alarm;
      case (r_state)
         S_IDLE: begin
            if (enable_i) begin
               w_state_nxt      = S_COUNT;
               w_bb_cnt_nxt     = '0;
               w_marker_cnt_nxt = '0;
            end
         end
         S_COUNT: begin
            if (!enable_i) begin
               w_state_nxt = S_IDLE;
            end else if (flush_i) begin
               w_bb_cnt_nxt = '0;
            end else if (w_accept && w_is_marker) begin
               w_bb_cnt_nxt = '0;
               if (r_marker_cnt != '1) begin
                  w_marker_cnt_nxt = r_marker_cnt + MARKER_CNT_WIDTH'(1);
               end
            end else if (w_accept) begin
               if (r_bb_cnt == CNT_W'(MAX_BB_LEN)) begin
                  w_state_nxt  = S_ALARM;
                  w_bb_cnt_nxt = CNT_W'(MAX_BB_LEN + 1);
                  w_alarm_nxt  = 1'b1;
               end else begin
                  w_bb_cnt_nxt = r_bb_cnt + CNT_W'(1);
               end
            end
         end
         S_ALARM: begin
            // Disable wins over clear; instructions and flushes are ignored here.
            if (!enable_i) begin
               w_state_nxt = S_IDLE;
               w_alarm_nxt = 1'b0;
            end else if (clear_i) begin
               w_state_nxt  = S_COUNT;
               w_bb_cnt_nxt = '0;
               w_alarm_nxt  = 1'b0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_alarm_nxt = 1'b0;
         end
      endcase
   end

   assign alarm_o      = r_alarm;
   assign bb_cnt_o     = r_bb_cnt;
   assign marker_cnt_o = r_marker_cnt;

endmodule

// File: tb/tb_cv32e40p_lce_detector.sv
// Directed self-checking bench for cv32e40p_lce_detector (MAX_BB_LEN=8), plus a
// second instance with a 2-bit marker counter that shares the same stimulus, for saturation.
module tb_cv32e40p_lce_detector;

   localparam logic [31:0] ADDI   = 32'h0010_0093;
   localparam logic [31:0] MARKER = 32'h0000_006F;

   logic        clk;
   logic        rst_n;
   logic        enable_i;
   logic        instr_valid_i;
   logic [31:0] instr_i;
   logic        flush_i;
   logic        clear_i;
   logic        alarm_o;
   logic [3:0]  bb_cnt_o;
   logic [15:0] marker_cnt_o;
   logic        sat_alarm_o;
   logic [3:0]  sat_bb_cnt_o;
   logic [1:0]  sat_marker_cnt_o;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   cv32e40p_lce_detector #(.MAX_BB_LEN(8), .MARKER_CNT_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .instr_valid_i(instr_valid_i),
      .instr_i(instr_i), .flush_i(flush_i), .clear_i(clear_i),
      .alarm_o(alarm_o), .bb_cnt_o(bb_cnt_o), .marker_cnt_o(marker_cnt_o)
   );

   cv32e40p_lce_detector #(.MAX_BB_LEN(8), .MARKER_CNT_WIDTH(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .enable_i(enable_i), .instr_valid_i(instr_valid_i),
      .instr_i(instr_i), .flush_i(flush_i), .clear_i(clear_i),
      .alarm_o(sat_alarm_o), .bb_cnt_o(sat_bb_cnt_o), .marker_cnt_o(sat_marker_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock with the given instruction presented; outputs are stable on return.
   task automatic send(input logic valid, input logic [31:0] word);
      instr_valid_i = valid;
      instr_i       = word;
      @(posedge clk);
      #1;
      instr_valid_i = 1'b0;
      instr_i       = 32'h0;
   endtask

   task automatic idle_cycle();
      send(1'b0, 32'h0);
   endtask

   initial begin
      rst_n = 1'b0; enable_i = 1'b0; instr_valid_i = 1'b0; instr_i = 32'h0;
      flush_i = 1'b0; clear_i = 1'b0;
      #12;
      check_eq("rst_alarm", 32'(alarm_o), 32'd0);
      check_eq("rst_bb", 32'(bb_cnt_o), 32'd0);
      check_eq("rst_marker", 32'(marker_cnt_o), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      enable_i = 1'b1;
      idle_cycle();

      // Legal stream: 8 ADDI + marker, five times.
      for (int r = 0; r < 5; r++) begin
         for (int i = 0; i < 8; i++) send(1'b1, ADDI);
         check_eq("legal_peak_bb", 32'(bb_cnt_o), 32'd8);
         check_eq("legal_peak_alarm", 32'(alarm_o), 32'd0);
         send(1'b1, MARKER);
         check_eq("legal_marker_bb", 32'(bb_cnt_o), 32'd0);
      end
      check_eq("legal_marker_cnt", 32'(marker_cnt_o), 32'd5);
      check_eq("legal_alarm", 32'(alarm_o), 32'd0);
      check_eq("sat_marker_cnt", 32'(sat_marker_cnt_o), 32'd3);

      // Missing marker: the ninth ADDI trips the alarm.
      for (int i = 0; i < 8; i++) send(1'b1, ADDI);
      check_eq("miss_bb8", 32'(bb_cnt_o), 32'd8);
      check_eq("miss_noalarm8", 32'(alarm_o), 32'd0);
      send(1'b1, ADDI);
      check_eq("miss_alarm", 32'(alarm_o), 32'd1);
      check_eq("miss_bb9", 32'(bb_cnt_o), 32'd9);
      send(1'b1, MARKER);
      flush_i = 1'b1;
      send(1'b1, ADDI);
      flush_i = 1'b0;
      check_eq("alarm_sticky", 32'(alarm_o), 32'd1);
      check_eq("alarm_bb_frozen", 32'(bb_cnt_o), 32'd9);
      check_eq("alarm_marker_ign", 32'(marker_cnt_o), 32'd5);

      // Clear returns to COUNT with a fresh block.
      clear_i = 1'b1;
      idle_cycle();
      clear_i = 1'b0;
      check_eq("clear_alarm", 32'(alarm_o), 32'd0);
      check_eq("clear_bb", 32'(bb_cnt_o), 32'd0);
      check_eq("clear_marker_kept", 32'(marker_cnt_o), 32'd5);
      send(1'b1, ADDI);
      check_eq("clear_counting", 32'(bb_cnt_o), 32'd1);

      // Flush restart, and flush beating a simultaneous marker.
      for (int i = 0; i < 5; i++) send(1'b1, ADDI);
      check_eq("flush_pre_bb", 32'(bb_cnt_o), 32'd6);
      flush_i = 1'b1;
      send(1'b1, ADDI);
      flush_i = 1'b0;
      check_eq("flush_bb", 32'(bb_cnt_o), 32'd0);
      for (int i = 0; i < 8; i++) send(1'b1, ADDI);
      check_eq("flush_post_bb", 32'(bb_cnt_o), 32'd8);
      send(1'b1, MARKER);
      check_eq("flush_alarm", 32'(alarm_o), 32'd0);
      check_eq("flush_marker_cnt", 32'(marker_cnt_o), 32'd6);
      send(1'b1, ADDI);
      flush_i = 1'b1;
      send(1'b1, MARKER);
      flush_i = 1'b0;
      check_eq("flush_marker_drop", 32'(marker_cnt_o), 32'd6);
      check_eq("flush_marker_bb", 32'(bb_cnt_o), 32'd0);

      // Bubbles: 8 ADDI with 20 valid zero words mixed in.
      for (int i = 0; i < 8; i++) begin
         send(1'b1, ADDI);
         for (int b = 0; b < ((i < 4) ? 3 : 2); b++) send(1'b1, 32'h0);
      end
      check_eq("bubble_bb", 32'(bb_cnt_o), 32'd8);
      check_eq("bubble_alarm", 32'(alarm_o), 32'd0);
      send(1'b1, MARKER);
      check_eq("bubble_marker_bb", 32'(bb_cnt_o), 32'd0);
      check_eq("bubble_marker_cnt", 32'(marker_cnt_o), 32'd7);

      // Disable in ALARM wins over a simultaneous clear.
      for (int i = 0; i < 9; i++) send(1'b1, ADDI);
      check_eq("dis_pre_alarm", 32'(alarm_o), 32'd1);
      enable_i = 1'b0;
      clear_i  = 1'b1;
      idle_cycle();
      clear_i  = 1'b0;
      check_eq("dis_alarm", 32'(alarm_o), 32'd0);
      for (int i = 0; i < 9; i++) send(1'b1, ADDI);
      send(1'b1, MARKER);
      check_eq("dis_noalarm", 32'(alarm_o), 32'd0);
      check_eq("dis_marker_hold", 32'(marker_cnt_o), 32'd7);
      enable_i = 1'b1;
      idle_cycle();
      check_eq("reen_marker", 32'(marker_cnt_o), 32'd0);
      check_eq("reen_bb", 32'(bb_cnt_o), 32'd0);

      // Asynchronous reset while in ALARM.
      for (int i = 0; i < 9; i++) send(1'b1, ADDI);
      check_eq("ares_pre_alarm", 32'(alarm_o), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("ares_alarm", 32'(alarm_o), 32'd0);
      check_eq("ares_bb", 32'(bb_cnt_o), 32'd0);
      check_eq("ares_marker", 32'(marker_cnt_o), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      // First accepted ADDI lands in IDLE and is not counted.
      send(1'b1, ADDI);
      check_eq("ares_idle_bb", 32'(bb_cnt_o), 32'd0);
      send(1'b1, ADDI);
      check_eq("ares_count_bb", 32'(bb_cnt_o), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
